// File: rtl/mdu_ctrl.sv
// ============================================================================
// mdu_ctrl : multi-cycle MIPS multiply/divide unit with HI/LO and stall request
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);
  localparam logic [c_cnt_w-1:0] c_mult_n = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_n  = c_cnt_w'(DIV_CYCLES);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  logic               r_busy;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_hi, r_lo;
  logic [31:0]        r_pend_hi, r_pend_lo;
  logic               r_pend_we;

  logic               w_is_md, w_is_mv, w_accept, w_is_mul;
  logic [c_cnt_w-1:0] w_n;
  logic [63:0]        w_prod_s, w_prod_u;
  logic               w_sdiv;
  logic [31:0]        w_a_mag, w_b_mag, w_num, w_den_raw, w_den, w_uq, w_ur, w_q, w_r;
  logic [31:0]        w_pend_hi, w_pend_lo;
  logic               w_pend_we;

  assign w_is_md  = (mdu_op >= c_op_mult) && (mdu_op <= c_op_divu);
  assign w_is_mv  = (mdu_op == c_op_mthi) || (mdu_op == c_op_mtlo);
  assign w_accept = start & ~flush & ~r_busy & (w_is_md | w_is_mv);
  assign w_is_mul = (mdu_op == c_op_mult) || (mdu_op == c_op_multu);
  assign w_n      = w_is_mul ? c_mult_n : c_div_n;

  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide runs on magnitudes, then signs are restored; this also yields
  // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign w_sdiv    = (mdu_op == c_op_div);
  assign w_a_mag   = a[31] ? (32'd0 - a) : a;
  assign w_b_mag   = b[31] ? (32'd0 - b) : b;
  assign w_num     = w_sdiv ? w_a_mag : a;
  assign w_den_raw = w_sdiv ? w_b_mag : b;
  assign w_den     = (w_den_raw == 32'd0) ? 32'd1 : w_den_raw;
  assign w_uq      = w_num / w_den;
  assign w_ur      = w_num % w_den;
  assign w_q       = (w_sdiv && (a[31] ^ b[31])) ? (32'd0 - w_uq) : w_uq;
  assign w_r       = (w_sdiv && a[31]) ? (32'd0 - w_ur) : w_ur;

  always_comb begin
    w_pend_hi = w_r;
    w_pend_lo = w_q;
    w_pend_we = (b != 32'd0);
    if (mdu_op == c_op_mult) begin
      {w_pend_hi, w_pend_lo} = w_prod_s;
      w_pend_we              = 1'b1;
    end else if (mdu_op == c_op_multu) begin
      {w_pend_hi, w_pend_lo} = w_prod_u;
      w_pend_we              = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else if (w_accept) begin
      if (w_is_md) begin
        r_busy    <= 1'b1;
        r_cnt     <= w_n;
        r_pend_hi <= w_pend_hi;
        r_pend_lo <= w_pend_lo;
        r_pend_we <= w_pend_we;
      end else if (mdu_op == c_op_mthi) begin
        r_hi <= a;
      end else begin
        r_lo <= a;
      end
    end else if (r_busy) begin
      r_cnt <= r_cnt - c_one;
      // Divide-by-zero leaves HI/LO untouched at the end of the countdown.
      if (r_cnt == c_one) begin
        r_busy <= 1'b0;
        if (r_pend_we) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end
  end

  assign busy  = r_busy;
  assign stall = r_busy | (start & w_is_md);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// tb_mdu_ctrl : scoreboard bench for the multiply/divide unit
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] sb_q[$];

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .a(a), .b(b),
    .flush(flush), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    longint p;
    int     q, r;
    model = cur;
    case (op)
      3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); model = p; end
      3'd2: model = {32'b0, x} * {32'b0, y};
      3'd3: if (y != 32'd0) begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          model = {r, q};
        end
      end
      3'd4: if (y != 32'd0) model = {x % y, x / y};
      3'd5: model = {x, cur[31:0]};
      3'd6: model = {cur[63:32], x};
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; mdu_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_arith(input string nm, input logic [2:0] op, input logic [31:0] x,
                            input logic [31:0] y, input int n);
    logic [63:0] exp;
    int cyc;
    bit early;
    sb_q.push_back(model(op, x, y, {m_hi, m_lo}));
    issue(op, x, y);
    cyc = 0; early = 0;
    while (busy === 1'b1 && cyc < 40) begin
      if ({hi, lo} !== {m_hi, m_lo}) early = 1;
      @(posedge clk); #1; cyc++;
    end
    total++; if (cyc != n) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, cyc, n); end
    total++; if (early) begin bad++; $display("FAIL %s_early_commit got=changed exp=unchanged", nm); end
    exp = sb_q.pop_front();
    total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL %s_result got=%h exp=%h", nm, {hi, lo}, exp); end
    {m_hi, m_lo} = exp;
  endtask

  task automatic test_move(input string nm, input logic [2:0] op, input logic [31:0] x);
    logic [63:0] exp;
    sb_q.push_back(model(op, x, 32'd0, {m_hi, m_lo}));
    @(negedge clk);
    start = 1'b1; mdu_op = op; a = x;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s_stall got=%b exp=0", nm, stall); end
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b exp=0", nm, busy); end
    exp = sb_q.pop_front();
    total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL %s_result got=%h exp=%h", nm, {hi, lo}, exp); end
    {m_hi, m_lo} = exp;
  endtask

  task automatic test_ignore_busy();
    logic [63:0] exp;
    int cyc;
    sb_q.push_back(model(3'd1, 32'd3, 32'd4, {m_hi, m_lo}));
    issue(3'd1, 32'd3, 32'd4);
    issue(3'd3, 32'd100, 32'd3);
    cyc = 1;
    while (busy === 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc != MC) begin bad++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", cyc, MC); end
    exp = sb_q.pop_front();
    total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL ignore_result got=%h exp=%h", {hi, lo}, exp); end
    {m_hi, m_lo} = exp;
    test_arith("reissue_div", 3'd3, 32'd100, 32'd3, DC);
  endtask

  task automatic test_flush();
    @(negedge clk);
    start = 1'b1; flush = 1'b1; mdu_op = 3'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; mdu_op = 3'd0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    repeat (MC + 1) @(posedge clk);
    #1;
    total++; if ({hi, lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL flush_hilo got=%h exp=%h", {hi, lo}, {m_hi, m_lo}); end
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    int cyc;
    bit drop;
    sb_q.push_back(model(3'd1, 32'd6, 32'd7, {m_hi, m_lo}));
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd1; a = 32'd6; b = 32'd7;
    #1;
    total++; if (stall !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL stall_accept got=%b%b exp=10", stall, busy); end
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0;
    cyc = 0; drop = 0;
    while (busy === 1'b1 && cyc < 40) begin
      if (stall !== 1'b1) drop = 1;
      @(posedge clk); #1; cyc++;
    end
    total++; if (drop || cyc != MC) begin bad++; $display("FAIL stall_busy got=drop%0d/cyc%0d exp=drop0/cyc%0d", drop, cyc, MC); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_after got=%b exp=0", stall); end
    exp = sb_q.pop_front();
    total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL stall_result got=%h exp=%h", {hi, lo}, exp); end
    {m_hi, m_lo} = exp;
  endtask

  task automatic test_async_reset();
    issue(3'd3, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b exp=0", busy); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL areset_hilo got=%h exp=0", {hi, lo}); end
    @(negedge clk); reset = 1'b0;
    sb_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (DC + 5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin bad++; $display("FAIL areset_after got=%b/%h exp=0/0", busy, {hi, lo}); end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] x, y;
    test_reset();
    test_arith("mult_neg", 3'd1, 32'hFFFF_FFFB, 32'd2, MC);
    test_arith("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, MC);
    test_arith("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, DC);
    test_arith("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    test_move("mthi_pre", 3'd5, 32'h11);
    test_move("mtlo_pre", 3'd6, 32'h22);
    test_arith("divu_zero", 3'd4, 32'd7, 32'd0, DC);
    test_move("mthi", 3'd5, 32'h1234);
    test_ignore_busy();
    test_flush();
    test_stall();
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      x  = $urandom;
      y  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      test_arith("rand", op, x, y, (op <= 3'd2) ? MC : DC);
    end
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller for the pipelined MIPS core, placed in EX next to the ALU.
- Accepts mult/multu/div/divu and mthi/mtlo from EX and runs a fixed-latency busy countdown.
- Commits the HI/LO registers when the countdown ends.
- Drives a stall request so the hazard unit holds younger mfhi/mflo and mult/div instructions until HI/LO are valid.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  EX-stage instruction is a valid MDU op this cycle
mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
b  input  32  rt operand (divisor / multiplier)
flush  input  1  EX instruction is cancelled (exception or interrupt); blocks acceptance
busy  output  1  multi-cycle operation in flight
stall  output  1  hazard request to the pipeline: busy | (start & mdu_op in 1..4)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, active-high):
  - busy=0, hi=0, lo=0, countdown=0, pending result discarded.
  - Applies immediately, including mid-operation.
- Acceptance: an op is accepted at the rising edge where start=1, flush=0, busy=0 and mdu_op is in 1..6. Any other combination is ignored with no state change.
- mthi/mtlo (op 5/6):
  - At the accept edge, hi<=a (mthi) or lo<=a (mtlo). The other register is unchanged.
  - busy stays 0, latency 1 edge, no stall.
- mult/multu/div/divu (op 1..4):
  - At the accept edge (t0), latch the 64-bit product or the quotient/remainder into internal pending registers.
  - Load countdown with N (MULT_CYCLES or DIV_CYCLES) and set busy=1.
- Countdown:
  - Decrements once per edge while busy=1.
  - At edge t0+N: hi/lo <= pending, busy<=0. busy is high for exactly N cycles.
  - The next op may be accepted at the first edge where busy is observed 0 (edge t0+N+1 at the earliest).
- Multiply arithmetic:
  - mult: signed 32x32 -> 64. multu: unsigned. {hi,lo} = product.
- Divide arithmetic:
  - div: signed, quotient truncates toward zero, remainder takes the sign of the dividend. lo=quotient, hi=remainder.
  - divu: unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- Divide by zero (b=0, div or divu):
  - Still busy for DIV_CYCLES.
  - At the end, hi/lo are unchanged (no write).
- Accept priority and exceptions:
  - start while busy=1 is ignored; the pipeline is already stalled by stall=1.
  - flush=1 with start=1 on the same edge: not accepted.
  - flush while busy=1 does not abort; the in-flight op completes and commits. This matches MIPS semantics, since the mult/div already retired past EX.
- stall is combinational: it is asserted in the accept cycle (before busy rises) and throughout busy. It is deasserted in the cycle busy=0 with no new MDU op.
- hi/lo outputs are registers only. Reads are never forwarded from pending.

Test Plan:
- Reset -> busy=0, hi=0, lo=0. Then mult a=0xFFFFFFFB(-5) b=2 -> busy high 5 cycles; after edge t0+5, hi=0xFFFFFFFF, lo=0xFFFFFFF6; hi/lo unchanged before that edge.
- multu a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. div a=-7 b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=7 b=0 after preloading hi=0x11, lo=0x22 via mthi/mtlo -> busy 10 cycles, then hi=0x11, lo=0x22. mthi a=0x1234 -> hi=0x1234 on the next edge, busy never asserted.
- mult started, then start=1 div on cycle 2 of busy -> div ignored; only mult result commits. Re-issue div after busy falls -> accepted. start=1 with flush=1 -> no busy, hi/lo unchanged.
- Reset asserted asynchronously in cycle 3 of a div -> busy, hi and lo go 0 immediately. After reset release, nothing commits.
- stall check: start mult with busy=0 -> stall=1 in that cycle (busy=0), stall=1 for the 5 busy cycles, stall=0 afterwards.
